// File: rtl/cordic_vectoring_if.sv
// ---------------------------------------------------------------------------
// cordic_vectoring_if
//   Request/result bundle for the vectoring CORDIC.
//   master: drives start, x_in, y_in; observes busy, done, z_out, mag_out.
//   slave : the converter itself.
//   Signals:
//     start    request, sampled only while the converter is idle
//     x_in     signed cos component, width+1 bits
//     y_in     signed sin component, width+1 bits
//     busy     conversion in progress
//     done     one-cycle pulse, z_out/mag_out valid from then on
//     z_out    unsigned angle, full turn = 2^32
//     mag_out  unsigned vector magnitude, width+2 bits
// ---------------------------------------------------------------------------
interface cordic_vectoring_if #(
  parameter int width = 16
);
  logic                  start;
  logic signed [width:0] x_in;
  logic signed [width:0] y_in;
  logic                  busy;
  logic                  done;
  logic [31:0]           z_out;
  logic [width+1:0]      mag_out;

  modport master (
    output start, x_in, y_in,
    input  busy, done, z_out, mag_out
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, z_out, mag_out
  );
endinterface

// File: rtl/cordic_vectoring.sv
// ---------------------------------------------------------------------------
// cordic_vectoring
//   Iterative vectoring-mode CORDIC: converts a (cos, sin) sample pair into an
//   angle (full turn = 2^32) and a magnitude. One micro-rotation per clock.
//   A request taken at edge k raises done after edge k+ITERS+1; one
//   conversion per ITERS+2 cycles when start is held high.
//
//   Parameters:
//     width  input magnitude bits (inputs are signed [width:0])
//     ITERS  micro-rotations per conversion, 1..24
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    cordic_vectoring_if.slave (start/x_in/y_in in,
//            busy/done/z_out/mag_out out)
//
//   Build option:
//     CORDIC_VEC_GAIN_COMP_EN  when defined, mag_out has the CORDIC gain
//                              removed (x * 19898 >>> 15); otherwise mag_out
//                              is the raw x including the ~1.6468 gain.
// ---------------------------------------------------------------------------
module cordic_vectoring #(
  parameter int width = 16,
  parameter int ITERS = 16
) (
  input logic               clk,
  input logic               reset,
  cordic_vectoring_if.slave bus
);

  // Two guard bits above the input range cover sqrt(2) * 1.647 growth.
  localparam int XW = width + 3;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  // round(atan(2^-i) / (2*pi) * 2^32); entries past 23 are never addressed.
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd0,         32'd0,         32'd0,         32'd0,
    32'd0,         32'd0,         32'd0,         32'd0
  };

  state_t               state_q, state_d;
  logic [4:0]           iter_q;
  logic signed [XW-1:0] x_q, y_q;
  logic [31:0]          z_q;
  logic                 done_q;
  logic [31:0]          z_out_q;
  logic [width+1:0]     mag_q;

  logic signed [XW-1:0] x_ext, y_ext;
  logic signed [XW-1:0] x_shr, y_shr;
  logic                 last_iter;
  logic [width+1:0]     mag_next;

  assign last_iter = (iter_q == 5'(ITERS - 1));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ROT;
      ROT:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  assign x_ext = {{2{bus.x_in[width]}}, bus.x_in};
  assign y_ext = {{2{bus.y_in[width]}}, bus.y_in};
  assign x_shr = x_q >>> iter_q;
  assign y_shr = y_q >>> iter_q;

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // 19898 / 2^15 ~= 0.60725 = 1 / CORDIC gain.
  localparam logic signed [16:0] GAIN_INV = 17'sd19898;
  logic signed [XW+16:0] mag_prod;

  always_comb begin
    mag_prod = x_q * GAIN_INV;
    mag_next = (width+2)'(mag_prod >>> 15);
  end
`else
  always_comb begin
    mag_next = (width+2)'(x_q);
  end
`endif

  // ---------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------
  // NOTE: every register here uses <= so each micro-rotation reads the
  // x/y/z values from before the edge, which the cross-coupled update needs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      z_out_q <= '0;
      mag_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Fold the left half-plane onto the right so the micro-rotations
            // only have to cover +/-90 degrees.
            if (bus.x_in[width]) begin
              x_q <= -x_ext;
              y_q <= -y_ext;
              z_q <= 32'h8000_0000;
            end else begin
              x_q <= x_ext;
              y_q <= y_ext;
              z_q <= '0;
            end
            iter_q <= '0;
          end
        end
        ROT: begin
          // Rotate toward the x axis: y >= 0 rotates clockwise.
          if (!y_q[XW-1]) begin
            x_q <= x_q + y_shr;
            y_q <= y_q - x_shr;
            z_q <= z_q + ATAN_TAB[iter_q];
          end else begin
            x_q <= x_q - y_shr;
            y_q <= y_q + x_shr;
            z_q <= z_q - ATAN_TAB[iter_q];
          end
          iter_q <= iter_q + 5'd1;
        end
        DONE: begin
          done_q  <= 1'b1;
          z_out_q <= z_q;
          mag_q   <= mag_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.z_out   = z_out_q;
  assign bus.mag_out = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring
//   Directed and randomized checks of cordic_vectoring against a reference
//   built from real-valued atan2/sqrt. Covers reset state, the four axes and
//   the 45-degree point, the (0,0) input, a full-circle sweep, random
//   vectors, start held high, and reset in the middle of a conversion.
//   Build option CORDIC_VEC_GAIN_COMP_EN selects the compensated magnitude.
// ---------------------------------------------------------------------------
module tb_cordic_vectoring;

  localparam int     W     = 16;
  localparam int     ITERS = 16;
  localparam int     LAT   = ITERS + 1;   // edges from the start edge to done
  localparam real    PI    = 3.14159265358979323846;
  localparam real    TWO32 = 4294967296.0;
  localparam longint MOD32 = longint'(1) << 32;

  // Full-scale axis points carry little shift-truncation noise; arbitrary
  // vectors pick up a few LSB per stage, so they get a wider band.
  localparam longint Z_TOL       = 65536;
  localparam longint Z_TOL_NOISY = 262144;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam bit  COMP          = 1'b1;
  localparam real MAG_TOL       = 4.0;
  localparam real MAG_TOL_NOISY = 8.0;
`else
  localparam bit  COMP          = 1'b0;
  localparam real MAG_TOL       = 8.0;
  localparam real MAG_TOL_NOISY = 16.0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cordic_vectoring_if #(.width(W)) bus ();

  cordic_vectoring #(
    .width(W),
    .ITERS(ITERS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic real cordic_gain();
    real g = 1.0;
    for (int i = 0; i < ITERS; i++) g = g * $sqrt(1.0 + 2.0 ** (-2 * i));
    return g;
  endfunction

  function automatic longint ref_angle(input int x, input int y);
    real    a = $atan2(real'(y), real'(x));
    longint z;
    if (a < 0.0) a = a + 2.0 * PI;
    z = longint'(a / (2.0 * PI) * TWO32);
    if (z >= MOD32) z = z - MOD32;
    return z;
  endfunction

  function automatic real ref_mag(input int x, input int y);
    real r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return COMP ? r : r * cordic_gain();
  endfunction

  // Angle accumulated when every step rotates the same way.
  function automatic longint ref_table_sum();
    real s = 0.0;
    for (int i = 0; i < ITERS; i++) s = s + $atan(2.0 ** (-i));
    return longint'(s / (2.0 * PI) * TWO32);
  endfunction

  // ---------------------------------------------------------------------
  // Comparisons
  // ---------------------------------------------------------------------
  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_angle(input string tag, input longint obs, input longint exp,
                             input longint tol);
    longint d = (obs - exp) % MOD32;
    logic   ok;
    if (d < 0) d = d + MOD32;
    if (d >= MOD32 / 2) d = d - MOD32;
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic check_mag(input string tag, input longint obs, input real exp,
                           input real tol);
    real  d = real'(obs) - exp;
    logic ok;
    if (d < 0.0) d = -d;
    ok = (d <= tol);
    checks++;
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0.1f +/-%0.1f", tag, obs, exp, tol);
    end
  endtask

  // ---------------------------------------------------------------------
  // One conversion: start for a single edge, then wait (bounded) for done.
  // Inputs are scrambled right after capture to show they are not re-read.
  // ---------------------------------------------------------------------
  task automatic convert(input int x, input int y, output longint z, output longint mag,
                         output int lat, output bit busy_ok);
    @(negedge clk);
    bus.x_in  = (W+1)'(x);
    bus.y_in  = (W+1)'(y);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = (W+1)'($urandom);
    bus.y_in  = (W+1)'($urandom);
    busy_ok   = bus.busy;
    lat       = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    z   = bus.z_out;
    mag = bus.mag_out;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int     dx [5] = '{32000, 0, -32000, 0, 22627};
    int     dy [5] = '{0, 32000, 0, -32000, 22627};
    longint z, mag;
    int     lat;
    bit     busy_ok;
    int     x, y, r;
    real    a;
    int     dones, pos1, pos2;
    longint z1, z2;
    int     seen;

    // Reset state.
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_z", bus.z_out, 0);
    check_eq("reset_mag", bus.mag_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // Axis and diagonal points with exact latency and busy framing.
    for (int i = 0; i < 5; i++) begin
      convert(dx[i], dy[i], z, mag, lat, busy_ok);
      check_eq($sformatf("dir%0d_latency", i), lat, LAT);
      check_eq($sformatf("dir%0d_busy", i), busy_ok, 1);
      check_angle($sformatf("dir%0d_z", i), z, ref_angle(dx[i], dy[i]), Z_TOL);
      check_mag($sformatf("dir%0d_mag", i), mag, ref_mag(dx[i], dy[i]), MAG_TOL);
      if (i == 0) begin
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", bus.done, 0);
        check_eq("z_held", bus.z_out, z);
      end
    end

    // (0,0): every step rotates clockwise, result is the table sum.
    convert(0, 0, z, mag, lat, busy_ok);
    check_eq("zero_latency", lat, LAT);
    check_angle("zero_z", z, ref_table_sum(), 16);
    check_eq("zero_mag", mag, 0);

    // Full-circle sweep at nominal amplitude, one point per degree.
    for (int deg = 0; deg < 360; deg++) begin
      a = real'(deg) * PI / 180.0;
      x = int'(32000.0 * $cos(a));
      y = int'(32000.0 * $sin(a));
      convert(x, y, z, mag, lat, busy_ok);
      check_angle($sformatf("sweep%0d_z", deg), z,
                  longint'(real'(deg) / 360.0 * TWO32) % MOD32, Z_TOL_NOISY);
      if (deg % 30 == 0)
        check_mag($sformatf("sweep%0d_mag", deg), mag, ref_mag(x, y), MAG_TOL_NOISY);
    end

    // Random vectors of varying length.
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(24000, 60000));
      a = real'($urandom_range(0, 35999)) / 100.0 * PI / 180.0;
      x = int'(real'(r) * $cos(a));
      y = int'(real'(r) * $sin(a));
      convert(x, y, z, mag, lat, busy_ok);
      check_eq($sformatf("rand%0d_latency", n), lat, LAT);
      check_angle($sformatf("rand%0d_z(%0d,%0d)", n, x, y), z, ref_angle(x, y), Z_TOL_NOISY);
      check_mag($sformatf("rand%0d_mag(%0d,%0d)", n, x, y), mag, ref_mag(x, y), MAG_TOL_NOISY);
    end

    // Start held high: the first vector is captured, the changed inputs are
    // not picked up until the converter is idle again.
    @(negedge clk);
    bus.x_in  = 17'sd32000;
    bus.y_in  = 17'sd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.x_in = 17'sd0;
    bus.y_in = 17'sd32000;
    dones = 0;
    pos1  = -1;
    pos2  = -1;
    z1    = 0;
    z2    = 0;
    for (int e = 1; e <= 2 * ITERS + 3; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          pos1 = e;
          z1   = bus.z_out;
        end else begin
          pos2 = e;
          z2   = bus.z_out;
        end
      end
    end
    bus.start = 1'b0;
    check_eq("held_done_count", dones, 2);
    check_eq("held_first_done_edge", pos1, LAT);
    check_eq("held_second_done_edge", pos2, LAT + ITERS + 2);
    check_angle("held_first_z", z1, ref_angle(32000, 0), Z_TOL);
    check_angle("held_second_z", z2, ref_angle(0, 32000), Z_TOL);

    // Reset at iteration 5: outputs clear, no done ever appears.
    @(negedge clk);
    bus.x_in  = 17'sd22627;
    bus.y_in  = 17'sd22627;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_busy", bus.busy, 0);
    check_eq("midreset_done", bus.done, 0);
    check_eq("midreset_z", bus.z_out, 0);
    check_eq("midreset_mag", bus.mag_out, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (ITERS + 4) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check_eq("midreset_no_activity", seen, 0);

    // Normal operation after the abandoned conversion.
    convert(0, -32000, z, mag, lat, busy_ok);
    check_eq("post_reset_latency", lat, LAT);
    check_eq("post_reset_busy", busy_ok, 1);
    check_angle("post_reset_z", z, ref_angle(0, -32000), Z_TOL);
    check_mag("post_reset_mag", mag, ref_mag(0, -32000), MAG_TOL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
